// File: rtl/inst_sram_responder.sv
// Synchronous SRAM responder for an sram-style CPU memory port.
// One-cycle registered read latency, byte-enable writes (read-first),
// address window check with a registered error pulse, and an optional
// post-reset clear sequence so contents are defined without preload.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_INIT | clearing mem[cnt] to zero, one word per cycle; requests rejected
// ST_DONE | clear finished (or skipped); requests serviced until reset
module inst_sram_responder #(
  parameter int          ADDR_W        = 12,
  parameter logic [31:0] BASE_ADDR     = 32'h1c000000,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        init_done,
  output logic        access_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH];

  logic [31:0]       off;
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic [31:0]       rd_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              unused_off_lsb;

  // Offset wraps modulo 2^32, so addresses below the base land far out of range.
  assign off            = sram_addr - BASE_ADDR;
  assign idx            = off[ADDR_W+1:2];
  assign in_range       = (off[31:ADDR_W+2] == '0);
  assign rd_word        = mem[idx];
  assign unused_off_lsb = ^off[1:0];

  // Next-state, clear counter, memory write port and registered response.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdata = rd_word;
    case (state_q)
      ST_INIT: begin
        // The clear owns the write port; any request is rejected outright.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (&cnt_q) begin
          state_d = ST_DONE;
        end
        if (sram_en) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        if (sram_en) begin
          if (in_range) begin
            // Read-first: the response carries the word before this write.
            rdata_d = rd_word;
            if (|sram_we) begin
              mem_we = 1'b1;
              for (int b = 0; b < 4; b++) begin
                mem_wdata[8*b +: 8] = sram_we[b] ? sram_wdata[8*b +: 8]
                                                 : rd_word[8*b +: 8];
              end
            end
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_DONE;
      end
    endcase
  end

  // Control and response registers; memory contents are deliberately not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_ON_RESET ? ST_INIT : ST_DONE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Single write port shared by the clear sequence and requester writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign sram_rdata = rdata_q;
  assign access_err = err_q;
  assign init_done  = (state_q == ST_DONE);

endmodule
